inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum cycles in REQ without ImemAck before a timeout error; legal range 1..255.
REQ-002 Parameter NOP_INST, default 32'h00000000: value driven on Inst whenever InstValid=0.
REQ-003 Clk  in  1  the single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  asynchronous, active-low; Reset=0 forces reset state immediately, independent of Clk.
REQ-005 Addr  in  32  current PC Address from the PC register.
REQ-006 Flush  in  1  control redirect; the PC is being reloaded this cycle and any fetched or in-flight instruction is discarded.
REQ-007 ImemReq  out  1  instruction-memory request.
REQ-008 ImemAddr  out  32  request address; stable while ImemReq=1.
REQ-009 ImemAck  in  1  memory completion; ImemData valid in the same cycle.
REQ-010 ImemData  in  32  instruction word.
REQ-011 Inst  out  32  instruction to decode.
REQ-012 InstPC  out  32  address of Inst.
REQ-013 InstValid  out  1  Inst and InstPC valid.
REQ-014 InstReady  in  1  decode accepts Inst this cycle.
REQ-015 PCWrite  out  1  one-cycle enable that lets the PC advance to its next value.
REQ-016 ErrCode  out  2  00 none, 01 misaligned Addr, 10 timeout.

Function
REQ-017 The FSM SHALL have four states, IDLE, REQ, VALID and ERR, plus a DROP flag for discarding a flushed in-flight request.
REQ-018 IDLE SHALL last exactly one cycle and then go to REQ.
REQ-019 On entry to REQ, the block SHALL latch Addr into ImemAddr if Addr[1:0]==2'b00; otherwise it SHALL go to ERR with ErrCode=01 and SHALL NOT assert ImemReq.
REQ-020 In REQ, ImemReq SHALL be 1 and ImemAddr SHALL be held until ImemAck=1.
REQ-021 On ImemAck with DROP=0, the block SHALL capture ImemData into Inst and ImemAddr into InstPC, go to VALID, and drive InstValid=1 from the next cycle.
REQ-022 In VALID, the block SHALL hold Inst and InstPC stable while InstReady=0.
REQ-023 When InstReady=1 in VALID, the block SHALL assert PCWrite=1 for exactly that cycle and go to REQ, where the new Addr is latched.
REQ-024 PCWrite SHALL be 0 in every other state and cycle.
REQ-025 Flush in VALID SHALL clear InstValid at the next edge, assert no PCWrite, and go to REQ.
REQ-026 Flush in REQ while ImemAck=0 SHALL set DROP=1 and keep ImemReq held, because a request cannot be cancelled.
REQ-027 When ImemAck arrives with DROP=1, the block SHALL discard the data, clear DROP, and re-enter REQ next cycle to latch the redirected Addr.
REQ-028 Flush coincident with ImemAck in REQ SHALL discard the data and behave as in REQ-027.
REQ-029 A wait counter (8 bits) SHALL clear on REQ entry and increment each REQ cycle with ImemAck=0.
REQ-030 When the wait counter reaches MAX_WAIT, the block SHALL go to ERR with ErrCode=10 and drop ImemReq.
REQ-031 Timeout SHALL take precedence over Flush in the same cycle.
REQ-032 ERR SHALL be sticky: InstValid=0, ImemReq=0, PCWrite=0.
REQ-033 Flush in ERR SHALL clear ErrCode and go to REQ.
REQ-034 When InstValid=0, Inst SHALL equal NOP_INST and InstPC SHALL equal 0.
REQ-035 Best-case throughput SHALL be one instruction per 2 cycles (REQ with same-cycle ack, then VALID with InstReady=1).

Reset
REQ-036 Reset=0 SHALL asynchronously set: state IDLE, DROP=0, wait counter 0, ImemReq=0, ImemAddr=0, Inst=NOP_INST, InstPC=0, InstValid=0, PCWrite=0, ErrCode=00.
REQ-037 Reset asserted mid-request SHALL abandon the request without waiting for ImemAck; an ImemAck arriving after release while not in REQ SHALL be ignored.
REQ-038 After Reset rises, the first ImemReq SHALL occur on the 2nd posedge, once IDLE has completed.

Verification
REQ-039 Reset release with Addr=0 and ImemAck tied to 1 with ImemData=32'h20080005 -> ImemReq at cycle 2, InstValid=1 with Inst=32'h20080005 and InstPC=0 at cycle 3.
REQ-040 Same setup with InstReady=1 -> PCWrite pulses on each VALID cycle; PC stepping 0,4,8 yields InstPC 0,4,8 at 2-cycle spacing.
REQ-041 ImemAck delayed 3 cycles and InstReady=0 for 4 cycles -> ImemAddr stable throughout, Inst held, a single PCWrite only after InstReady=1.
REQ-042 Flush during REQ with ack pending, then ack -> no InstValid for that data, then a new ImemReq at the redirected Addr=32'h40.
REQ-043 Addr=32'h6 at REQ entry -> ErrCode=01, no ImemReq; ImemAck never asserted -> ErrCode=10 after 16 REQ cycles; Flush then clears ErrCode and restarts.
REQ-044 Reset pulsed low mid-REQ -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage sitting between the PC register and decode.
// It issues one instruction-memory request per PC value, presents the returned
// word to decode, and pulses PCWrite when decode accepts it. A flushed request
// that is already on the bus is allowed to finish and its data is thrown away.
//
// Ports
//   Clk        clock; all state changes on its rising edge
//   Reset      asynchronous active-low reset
//   Addr       current PC from the PC register
//   Flush      redirect: the PC is being reloaded, discard fetched/in-flight work
//   ImemReq    instruction-memory request
//   ImemAddr   request address, stable while ImemReq=1
//   ImemAck    memory completion, ImemData valid in the same cycle
//   ImemData   returned instruction word
//   Inst       instruction to decode (NOP_INST when InstValid=0)
//   InstPC     address of Inst (0 when InstValid=0)
//   InstValid  Inst/InstPC valid
//   InstReady  decode accepts Inst this cycle
//   PCWrite    one-cycle enable that advances the PC
//   ErrCode    00 none, 01 misaligned Addr, 10 request timeout
module inst_fetch #(
    parameter int unsigned MAX_WAIT = 16,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic        Flush,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    output logic        InstValid,
    input  logic        InstReady,
    output logic        PCWrite,
    output logic [1:0]  ErrCode
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic        req_first;   // first cycle of REQ: Addr is sampled live this cycle
    logic        drop;        // in-flight request was flushed, discard its data
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [1:0]  err_q;

    logic in_req;
    logic addr_ok;
    logic timeout;

    // The PC only advances at the edge that ends VALID, so the new Addr is
    // first visible during the first REQ cycle. ImemAddr therefore follows Addr
    // combinationally in that cycle and the registered copy holds it afterwards,
    // which is what allows a same-cycle ack and two-cycle throughput.
    always_comb begin
        in_req    = (state == S_REQ);
        addr_ok   = (Addr[1:0] == 2'b00);
        ImemReq   = in_req && (!req_first || addr_ok);
        ImemAddr  = (in_req && req_first) ? Addr : addr_q;
        timeout   = ImemReq && !ImemAck && (wait_cnt == WAIT_LAST);
        InstValid = (state == S_VALID);
        PCWrite   = (state == S_VALID) && InstReady && !Flush;
        Inst      = inst_q;
        InstPC    = pc_q;
        ErrCode   = err_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            req_first <= 1'b0;
            drop      <= 1'b0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            inst_q    <= NOP_INST;
            pc_q      <= '0;
            err_q     <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_REQ;
                    req_first <= 1'b1;
                    wait_cnt  <= '0;
                end

                S_REQ: begin
                    if (req_first && !addr_ok) begin
                        // No request was issued, so there is nothing to drain.
                        state     <= S_ERR;
                        err_q     <= ERR_MISALIGN;
                        req_first <= 1'b0;
                        drop      <= 1'b0;
                    end else begin
                        if (req_first) begin
                            addr_q <= Addr;
                        end
                        req_first <= 1'b0;
                        if (ImemAck) begin
                            if (drop || Flush) begin
                                // Discard and restart REQ to pick up the redirected PC.
                                drop      <= 1'b0;
                                req_first <= 1'b1;
                                wait_cnt  <= '0;
                            end else begin
                                inst_q <= ImemData;
                                pc_q   <= ImemAddr;
                                state  <= S_VALID;
                            end
                        end else if (timeout) begin
                            // Timeout wins over a same-cycle Flush.
                            state <= S_ERR;
                            err_q <= ERR_TIMEOUT;
                            drop  <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (Flush) begin
                                drop <= 1'b1;
                            end
                        end
                    end
                end

                S_VALID: begin
                    if (Flush || InstReady) begin
                        state     <= S_REQ;
                        req_first <= 1'b1;
                        wait_cnt  <= '0;
                        inst_q    <= NOP_INST;
                        pc_q      <= '0;
                    end
                end

                default: begin  // S_ERR: sticky until Flush
                    if (Flush) begin
                        err_q     <= ERR_NONE;
                        state     <= S_REQ;
                        req_first <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch. Each table row holds one
// cycle of inputs and the outputs expected during that cycle; rows are queued
// as they are driven and compared on the falling edge. Reset corner cases are
// exercised by hand-written sequences around the table.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        Clk;
    logic        Reset;
    logic [31:0] Addr;
    logic        Flush;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        InstValid;
    logic        InstReady;
    logic        PCWrite;
    logic [1:0]  ErrCode;

    inst_fetch #(.MAX_WAIT(16), .NOP_INST(NOP)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Flush(Flush),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
        .ImemData(ImemData), .Inst(Inst), .InstPC(InstPC),
        .InstValid(InstValid), .InstReady(InstReady), .PCWrite(PCWrite),
        .ErrCode(ErrCode)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic        f;
        logic        k;
        logic [31:0] d;
        logic        r;
        logic        req;
        logic [31:0] ia;
        logic        vl;
        logic [31:0] in;
        logic [31:0] pc;
        logic        pw;
        logic [1:0]  e;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t V(string tag, logic [31:0] a, logic f, logic k,
                               logic [31:0] d, logic r, logic req, logic [31:0] ia,
                               logic vl, logic [31:0] in, logic [31:0] pc,
                               logic pw, logic [1:0] e);
        vec_t v;
        v.tag = tag; v.a = a; v.f = f; v.k = k; v.d = d; v.r = r;
        v.req = req; v.ia = ia; v.vl = vl; v.in = in; v.pc = pc; v.pw = pw; v.e = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, ".ImemReq"},   32'(ImemReq),   32'd0);
        chk({tag, ".ImemAddr"},  ImemAddr,       32'd0);
        chk({tag, ".InstValid"}, 32'(InstValid), 32'd0);
        chk({tag, ".Inst"},      Inst,           NOP);
        chk({tag, ".InstPC"},    InstPC,         32'd0);
        chk({tag, ".PCWrite"},   32'(PCWrite),   32'd0);
        chk({tag, ".ErrCode"},   32'(ErrCode),   32'd0);
    endtask

    // Drive one row for a full cycle; returns 1 time unit after the next posedge.
    task automatic apply(vec_t v);
        Addr = v.a; Flush = v.f; ImemAck = v.k; ImemData = v.d; InstReady = v.r;
        sb.push_back(v);
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            vec_t m;
            m = sb.pop_front();
            chk({m.tag, ".ImemReq"}, 32'(ImemReq), 32'(m.req));
            if (m.req)
                chk({m.tag, ".ImemAddr"}, ImemAddr, m.ia);
            chk({m.tag, ".InstValid"}, 32'(InstValid), 32'(m.vl));
            chk({m.tag, ".Inst"},      Inst,           m.in);
            chk({m.tag, ".InstPC"},    InstPC,         m.pc);
            chk({m.tag, ".PCWrite"},   32'(PCWrite),   32'(m.pw));
            chk({m.tag, ".ErrCode"},   32'(ErrCode),   32'(m.e));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // ---- stimulus table ----
        // pipelined fetch, ack tied high, decode always ready
        tbl.push_back(V("idle",  32'h0, 0, 1, 32'h20080005, 1, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("req0",  32'h0, 0, 1, 32'h20080005, 1, 1, 32'h0, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("val0",  32'h0, 0, 1, 32'h20080005, 1, 0, 32'h0, 1, 32'h20080005, 32'h0, 1, 2'b00));
        tbl.push_back(V("req4",  32'h4, 0, 1, 32'h2009000A, 1, 1, 32'h4, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("val4",  32'h4, 0, 1, 32'h2009000A, 1, 0, 32'h4, 1, 32'h2009000A, 32'h4, 1, 2'b00));
        tbl.push_back(V("req8",  32'h8, 0, 1, 32'h200A000F, 1, 1, 32'h8, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("val8",  32'h8, 0, 1, 32'h200A000F, 1, 0, 32'h8, 1, 32'h200A000F, 32'h8, 1, 2'b00));
        // slow ack (Addr wiggled to prove ImemAddr holds), decode stalls 4 cycles
        tbl.push_back(V("b_req", 32'hC,   0, 0, 32'h0, 0, 1, 32'hC, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("b_w1",  32'h100, 0, 0, 32'h0, 0, 1, 32'hC, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("b_w2",  32'h100, 0, 0, 32'h0, 0, 1, 32'hC, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("b_ack", 32'h100, 0, 1, 32'h8C220000, 0, 1, 32'hC, 0, NOP, 32'h0, 0, 2'b00));
        for (int i = 0; i < 4; i++)
            tbl.push_back(V("b_hold", 32'hC, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8C220000, 32'hC, 0, 2'b00));
        tbl.push_back(V("b_rdy", 32'hC, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8C220000, 32'hC, 1, 2'b00));
        // flush while request pending, late ack discarded, refetch at 0x40
        tbl.push_back(V("c_req",   32'h10, 0, 0, 32'h0, 0, 1, 32'h10, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_flush", 32'h10, 1, 0, 32'h0, 0, 1, 32'h10, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_hold",  32'h40, 0, 0, 32'h0, 0, 1, 32'h10, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_ack",   32'h40, 0, 1, 32'h11111111, 0, 1, 32'h10, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_new",   32'h40, 0, 1, 32'h22222222, 0, 1, 32'h40, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_val",   32'h40, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h22222222, 32'h40, 0, 2'b00));
        // flush in VALID beats InstReady; flush coincident with ack discards
        tbl.push_back(V("c_vflush", 32'h40, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h22222222, 32'h40, 0, 2'b00));
        tbl.push_back(V("c_coinc",  32'h80, 1, 1, 32'h33333333, 0, 1, 32'h80, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_reent",  32'h84, 0, 1, 32'h44444444, 0, 1, 32'h84, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("c_val2",   32'h84, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h44444444, 32'h84, 1, 2'b00));
        // misaligned PC, sticky error, flush recovers
        tbl.push_back(V("d_mis",    32'h6,   0, 0, 32'h0, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("d_err",    32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b01));
        tbl.push_back(V("d_sticky", 32'h100, 0, 1, 32'h99, 1, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b01));
        tbl.push_back(V("d_flush",  32'h100, 1, 0, 32'h0, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b01));
        // 16 unacked REQ cycles -> timeout; flush in the last one must not win
        for (int i = 0; i < 16; i++)
            tbl.push_back(V("d_wait", 32'h100, (i == 15), 0, 32'h0, 0, 1, 32'h100, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("d_to",      32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b10));
        tbl.push_back(V("d_toflush", 32'h200, 1, 0, 32'h0, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b10));
        tbl.push_back(V("d_restart", 32'h200, 0, 1, 32'h55555555, 0, 1, 32'h200, 0, NOP, 32'h0, 0, 2'b00));
        tbl.push_back(V("d_val",     32'h200, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h55555555, 32'h200, 1, 2'b00));
        tbl.push_back(V("e_req",     32'h204, 0, 0, 32'h0, 0, 1, 32'h204, 0, NOP, 32'h0, 0, 2'b00));

        // ---- initial reset, with clock edges and ack present ----
        Reset = 1'b0; Addr = '0; Flush = 1'b0; ImemAck = 1'b1;
        ImemData = 32'h20080005; InstReady = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check_reset("rst0");
        Reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // ---- reset pulsed mid-request, no clock edge needed ----
        #2;
        chk("pre_rst.ImemReq",  32'(ImemReq), 32'd1);
        chk("pre_rst.ImemAddr", ImemAddr,     32'h204);
        Reset = 1'b0;
        #1;
        check_reset("rst_async");
        ImemAck = 1'b1; ImemData = 32'hBAD0BAD0;
        @(posedge Clk);
        #1;
        check_reset("rst_hold");
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        // ack held high through release must be ignored until REQ
        apply(V("r_idle", 32'h0, 0, 1, 32'h20080005, 0, 0, 32'h0, 0, NOP, 32'h0, 0, 2'b00));
        apply(V("r_req",  32'h0, 0, 1, 32'h20080005, 0, 1, 32'h0, 0, NOP, 32'h0, 0, 2'b00));
        apply(V("r_val",  32'h0, 0, 1, 32'h20080005, 0, 0, 32'h0, 1, 32'h20080005, 32'h0, 0, 2'b00));

        for (int i = 0; i < 4 && sb.size() != 0; i++)
            @(posedge Clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
